// File: rtl/fadd_ieee754_reg.sv
// Binary32 adder, round-to-nearest-even, result registered one cycle after in_valid.
// Build option: define FADD_SUBNORM_EN for gradual underflow; default flushes subnormals to zero.
module fadd_ieee754_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  output logic [31:0] out
);

  logic        sa, sb, a_nan, b_nan, a_inf, b_inf;
  logic [7:0]  xa, xb;
  logic [23:0] ma, mb;

  assign sa    = a[31];
  assign sb    = b[31];
  assign a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
  assign b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
  assign a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
  assign b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);

`ifdef FADD_SUBNORM_EN
  assign ma = {a[30:23] != 8'h00, a[22:0]};
  assign mb = {b[30:23] != 8'h00, b[22:0]};
  assign xa = (a[30:23] == 8'h00) ? 8'd1 : a[30:23];
  assign xb = (b[30:23] == 8'h00) ? 8'd1 : b[30:23];
`else
  assign ma = (a[30:23] == 8'h00) ? 24'h0 : {1'b1, a[22:0]};
  assign mb = (b[30:23] == 8'h00) ? 24'h0 : {1'b1, b[22:0]};
  assign xa = a[30:23];
  assign xb = b[30:23];
`endif

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       done;
    n    = 5'd0;
    done = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!done) begin
        if (v[i]) done = 1'b1;
        else      n = n + 5'd1;
      end
    end
    return n;
  endfunction

  logic        swap, sl, eff_sub, rnd, tiny, huge;
  logic [7:0]  xl, xs, diff, ef;
  logic [23:0] ml, ms;
  logic [49:0] wide;
  logic [26:0] al, norm, rnorm;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [9:0]  en;
  logic [30:0] packed_mag;
  logic [31:0] out_d, out_q;
  logic        out_valid_q;
`ifdef FADD_SUBNORM_EN
  logic [9:0]  sh;
  logic [53:0] wide2;
`endif

  always_comb begin
    swap = {xb, mb} > {xa, ma};
    sl   = swap ? sb : sa;
    xl   = swap ? xb : xa;
    ml   = swap ? mb : ma;
    xs   = swap ? xa : xb;
    ms   = swap ? ma : mb;
    eff_sub = sa ^ sb;
    diff = xl - xs;
    wide = {ms, 26'h0} >> diff;
    // Beyond 25 positions nothing reaches guard/round, so only stickiness survives.
    if (diff >= 8'd26) al = {26'h0, |ms};
    else               al = {wide[49:24], |wide[23:0]};
    sum = eff_sub ? ({1'b0, ml, 3'b000} - {1'b0, al})
                  : ({1'b0, ml, 3'b000} + {1'b0, al});
    lz = lzc27(sum[26:0]);
    if (sum[27]) begin
      norm = {sum[27:2], |sum[1:0]};
      en   = {2'b00, xl} + 10'd1;
    end else begin
      norm = sum[26:0] << lz;
      en   = {2'b00, xl} - {5'd0, lz};
    end
    tiny = en[9] || (en == 10'd0);
    huge = !en[9] && (en >= 10'd255);
`ifdef FADD_SUBNORM_EN
    sh    = 10'd1 - en;
    wide2 = {norm, 27'h0} >> sh[4:0];
    if (!tiny) begin
      rnorm = norm;
      ef    = en[7:0];
    end else begin
      rnorm = (sh >= 10'd27) ? {26'h0, |norm} : {wide2[53:28], |wide2[27:0]};
      ef    = 8'd0;
    end
`else
    rnorm = norm;
    ef    = en[7:0];
`endif
    rnd = rnorm[2] & (rnorm[1] | rnorm[0] | rnorm[3]);
    // Carry out of the fraction bumps the exponent field: covers renormalize and subnormal->normal.
    packed_mag = {ef, rnorm[25:3]} + {30'h0, rnd};

    if (a_nan || b_nan || (a_inf && b_inf && (sa ^ sb))) out_d = 32'h7FC0_0000;
    else if (a_inf)         out_d = {sa, 8'hFF, 23'h0};
    else if (b_inf)         out_d = {sb, 8'hFF, 23'h0};
    else if (sum == 28'h0)  out_d = {sa & sb, 31'h0};
    else if (huge)          out_d = {sl, 8'hFF, 23'h0};
`ifndef FADD_SUBNORM_EN
    else if (tiny)          out_d = {sl, 31'h0};
`endif
    else                    out_d = {sl, packed_mag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= 32'h0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) out_q <= out_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fadd_ieee754_reg.sv
// Scoreboard bench for fadd_ieee754_reg: directed vectors, random back-to-back traffic, bubbles, reset.
module tb_fadd_ieee754_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a, b;
  logic        out_valid;
  logic [31:0] dut_out;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_out;

  fadd_ieee754_reg dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out      (dut_out)
  );

  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] x);
    logic [10:0] e11;
    e11 = 11'(x[30:23]) + 11'd896;
    return $bitstoreal({x[31], e11, x[22:0], 29'h0});
  endfunction

  // Double-precision add is exact enough that a single RNE step to binary32 gives the correct result.
  function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
    real         rs;
    logic [63:0] d;
    logic [52:0] m;
    logic [23:0] keep;
    logic        rb;
    int          fe;
    logic [30:0] mag;
    rs = f2r(x) + f2r(y);
    if (rs == 0.0) return 32'h0;
    d    = $realtobits(rs);
    fe   = int'(d[62:52]) - 896;
    m    = {1'b1, d[51:0]};
    keep = m[52:29];
    rb   = m[28] & ((|m[27:0]) | keep[0]);
    mag  = {fe[7:0], keep[22:0]} + 31'(rb);
    return {d[63], mag};
  endfunction

  function automatic logic [31:0] rnd_norm(input logic [7:0] e);
    logic [31:0] r;
    r = $urandom;
    return {r[31], e, r[22:0]};
  endfunction

  task automatic test_reset_state();
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    n_cmp++;
    if (dut_out !== 32'h0) begin
      n_err++; $display("FAIL reset_out: got %h want 00000000", dut_out);
    end
    n_cmp++;
  endtask

  task automatic test_vectors();
    logic [31:0] va[14], vb[14], ve[14];
    logic [31:0] want;
    va = '{32'h4A3600CA, 32'hC96A3E8C, 32'h4A16B076, 32'h4AEFBD8E, 32'h4A9C31FF,
           32'h7F800000, 32'h7F7FFFFF, 32'h3F800000, 32'h7FC00001, 32'h00800001,
           32'h80000000, 32'h00000000, 32'h3F800000, 32'h7F800000};
    vb = '{32'hC93C97A8, 32'h496EF9C6, 32'hC8C608CB, 32'h49725577, 32'h49DCF026,
           32'hFF800000, 32'h7F7FFFFF, 32'hBF800000, 32'h3F800000, 32'h80800000,
           32'h80000000, 32'h80000000, 32'h3F800000, 32'h3F800000};
    ve = '{32'h4A06DAE0, 32'h46976740, 32'h49FBDEB9, 32'h4B07041E, 32'h4AD36E08,
           32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h7FC00000,
`ifdef FADD_SUBNORM_EN
           32'h00000001,
`else
           32'h00000000,
`endif
           32'h80000000, 32'h00000000, 32'h40000000, 32'h7F800000};
    for (int i = 0; i < 14; i++) begin
      a = va[i]; b = vb[i]; in_valid = 1'b1;
      exp_q.push_back(ve[i]);
      @(posedge clk); #1;
      want = exp_q.pop_front();
      if (out_valid !== 1'b1) begin
        n_err++; $display("FAIL vec%0d_valid: got %b want 1", i, out_valid);
      end
      n_cmp++;
      if (dut_out !== want) begin
        n_err++; $display("FAIL vec%0d %h+%h: got %h want %h", i, va[i], vb[i], dut_out, want);
      end
      n_cmp++;
      last_out = want;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0]  ea, eb;
    logic [31:0] want;
    for (int i = 0; i < 50; i++) begin
      ea = 8'($urandom_range(64, 190));
      eb = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(64, 190)) : ea - 8'($urandom_range(0, 2));
      a = rnd_norm(ea); b = rnd_norm(eb); in_valid = 1'b1;
      exp_q.push_back(ref_add(a, b));
      @(posedge clk); #1;
      want = exp_q.pop_front();
      if (out_valid !== 1'b1) begin
        n_err++; $display("FAIL b2b%0d_valid: got %b want 1", i, out_valid);
      end
      n_cmp++;
      if (dut_out !== want) begin
        n_err++; $display("FAIL b2b%0d %h+%h: got %h want %h", i, a, b, dut_out, want);
      end
      n_cmp++;
      last_out = want;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_bubbles();
    logic [31:0] want;
    for (int i = 0; i < 12; i++) begin
      a = rnd_norm(8'($urandom_range(100, 150)));
      b = rnd_norm(8'($urandom_range(100, 150)));
      in_valid = (i % 2 == 1);
      if (in_valid) exp_q.push_back(ref_add(a, b));
      @(posedge clk); #1;
      if (i % 2 == 1) begin
        want = exp_q.pop_front();
        if (out_valid !== 1'b1) begin
          n_err++; $display("FAIL bub%0d_valid: got %b want 1", i, out_valid);
        end
        n_cmp++;
        if (dut_out !== want) begin
          n_err++; $display("FAIL bub%0d_out: got %h want %h", i, dut_out, want);
        end
        n_cmp++;
        last_out = want;
      end else begin
        if (out_valid !== 1'b0) begin
          n_err++; $display("FAIL bub%0d_idle_valid: got %b want 0", i, out_valid);
        end
        n_cmp++;
        if (dut_out !== last_out) begin
          n_err++; $display("FAIL bub%0d_hold: got %h want %h", i, dut_out, last_out);
        end
        n_cmp++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    a = 32'h3F800000; b = 32'h3F800000; in_valid = 1'b1;
    @(posedge clk); #1;
    if (dut_out !== 32'h40000000) begin
      n_err++; $display("FAIL prereset_out: got %h want 40000000", dut_out);
    end
    n_cmp++;
    #2 rst_n = 1'b0;
    #1;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL midreset_valid: got %b want 0", out_valid);
    end
    n_cmp++;
    if (dut_out !== 32'h0) begin
      n_err++; $display("FAIL midreset_out: got %h want 00000000", dut_out);
    end
    n_cmp++;
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL postreset_valid: got %b want 0", out_valid);
      end
      n_cmp++;
      if (dut_out !== 32'h0) begin
        n_err++; $display("FAIL postreset_out: got %h want 00000000", dut_out);
      end
      n_cmp++;
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = 32'h0; b = 32'h0; last_out = 32'h0;
    #2;
    test_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    test_vectors();
    test_back_to_back();
    test_bubbles();
    test_reset();
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size());
    end
    n_cmp++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
